data_dump_uart: RTL and testbench

//  Post-halt readback stage downstream of the BIP data memory. On a start request it

---
 rtl/data_dump_uart.sv | 111 +++++++++++
 tb/tb_data_dump_uart.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_dump_uart.sv
// Post-halt readback: walks data memory words 0..N_WORDS-1 and hands each one to the
// UART transmitter as two bytes, high byte first.
module data_dump_uart #(
  parameter int N_WORDS = 10,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] word;

  // This block never writes the memory it reads back.
  assign mem_wr = 1'b0;

  // Outputs are set on the transition into the state that owns them, so every
  // strobe is a clean register output aligned with its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      word     <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RD_REQ;
            idx      <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RD_REQ: begin
          // Memory drives mem_data on the negedge inside this cycle.
          word     <= mem_data;
          tx_data  <= mem_data[15:8];
          tx_start <= 1'b1;
          state    <= SEND_HI;
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (tx_done) begin
            tx_data  <= word[7:0];
            tx_start <= 1'b1;
            state    <= SEND_LO;
          end
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (tx_done) begin
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx      <= idx + IDX_W'(1);
              mem_addr <= ADDR_W'(idx + IDX_W'(1));
              mem_rd   <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end
        DONE: begin
          idx   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_dump_uart.sv
// Directed bench: a 10-word dump instance and a 1-word instance, each with its own
// negedge memory model and UART-side responder.
module tb_data_dump_uart;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start0, mem_rd0, mem_wr0, tx_start0, tx_done0, busy0, done0;
  logic [10:0] mem_addr0;
  logic [15:0] mem_data0;
  logic [7:0]  tx_data0;

  logic        start1, mem_rd1, mem_wr1, tx_start1, tx_done1, busy1, done1;
  logic [10:0] mem_addr1;
  logic [15:0] mem_data1;
  logic [7:0]  tx_data1;

  data_dump_uart #(.N_WORDS(10), .ADDR_W(11), .DATA_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .mem_rd(mem_rd0), .mem_wr(mem_wr0),
    .mem_addr(mem_addr0), .mem_data(mem_data0), .tx_start(tx_start0), .tx_data(tx_data0),
    .tx_done(tx_done0), .busy(busy0), .done(done0)
  );

  data_dump_uart #(.N_WORDS(1), .ADDR_W(11), .DATA_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .tx_start(tx_start1), .tx_data(tx_data1),
    .tx_done(tx_done1), .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mem0 [0:15];
  logic [15:0] mem1 [0:15];
  logic [7:0]  byte_q0 [$];
  logic [7:0]  byte_q1 [$];
  int          addr_q0 [$];
  int          cyc = 0, done_cyc0 = 0, first_rd_cyc0 = 0;
  int          done_cnt0 = 0, done_cnt1 = 0, rd_cnt1 = 0, max_addr1 = 0;
  int          d0 = 3, d1 = 2, pend0 = 0, pend1 = 0;
  logic        noise_done = 1'b0, inject_spur = 1'b0;

  // Memory models, UART responders (tx_done d cycles after tx_start) and logging.
  always @(negedge clk) begin
    cyc++;
    tx_done0 = noise_done;
    if (pend0 == 1) tx_done0 = 1'b1;
    if (pend0 > 0) pend0--;
    if (tx_start0) begin
      if (inject_spur && (byte_q0.size() % 2 == 0)) tx_done0 = 1'b1;
      byte_q0.push_back(tx_data0);
      pend0 = d0;
    end
    if (mem_rd0) begin
      if (addr_q0.size() == 0) first_rd_cyc0 = cyc;
      addr_q0.push_back(int'(mem_addr0));
      mem_data0 = mem0[mem_addr0[3:0]];
    end
    if (done0) begin
      done_cnt0++;
      done_cyc0 = cyc;
    end

    tx_done1 = noise_done;
    if (pend1 == 1) tx_done1 = 1'b1;
    if (pend1 > 0) pend1--;
    if (tx_start1) begin
      byte_q1.push_back(tx_data1);
      pend1 = d1;
    end
    if (mem_rd1) begin
      rd_cnt1++;
      mem_data1 = mem1[mem_addr1[3:0]];
    end
    if (int'(mem_addr1) > max_addr1) max_addr1 = int'(mem_addr1);
    if (done1) done_cnt1++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    byte_q0.delete();
    addr_q0.delete();
    done_cnt0 = 0;
    pend0     = 0;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag, input int budget);
    int n = 0;
    while (done_cnt0 == 0 && n < budget) begin
      tick();
      n++;
    end
    check_output({tag, " done seen"}, 32'(done_cnt0 != 0), 32'd1);
  endtask

  task automatic check_dump0(input string tag);
    logic [7:0] exp_b, got_b;
    check_output({tag, " byte count"}, 32'(byte_q0.size()), 32'd20);
    check_output({tag, " read count"}, 32'(addr_q0.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check_output({tag, " read addr"}, (i < addr_q0.size()) ? addr_q0[i] : -1, i);
    for (int i = 0; i < 20; i++) begin
      exp_b = (i % 2 == 0) ? 8'h11 : 8'(i / 2);
      got_b = (i < byte_q0.size()) ? byte_q0[i] : 8'hxx;
      check_output({tag, " byte"}, {24'd0, got_b}, {24'd0, exp_b});
    end
  endtask

  initial begin
    reset       = 1'b1;
    start0      = 1'b0;
    start1      = 1'b0;
    tx_done0    = 1'b0;
    tx_done1    = 1'b0;
    mem_data0   = '0;
    mem_data1   = '0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 16'h1100 + 16'(i);
      mem1[i] = 16'h0000;
    end
    mem1[0] = 16'hBEEF;
    #2 reset = 1'b0;

    // Held in reset while the inputs thrash: nothing may move.
    for (int i = 0; i < 8; i++) begin
      tick();
      start0     = ~start0;
      start1     = ~start1;
      noise_done = ~noise_done;
      check_output("reset busy", {31'd0, busy0}, 32'd0);
    end
    noise_done = 1'b0;
    start0     = 1'b0;
    start1     = 1'b0;
    tick();
    check_output("reset mem_rd pulses", 32'(addr_q0.size()), 32'd0);
    check_output("reset tx_start pulses", 32'(byte_q0.size()), 32'd0);
    check_output("reset done", {31'd0, done0}, 32'd0);
    check_output("reset mem_addr", {21'd0, mem_addr0}, 32'd0);
    check_output("reset tx_data", {24'd0, tx_data0}, 32'd0);
    check_output("reset mem_wr", {31'd0, mem_wr0}, 32'd0);
    check_output("reset busy1", {31'd0, busy1}, 32'd0);
    check_output("reset rd1", 32'(rd_cnt1), 32'd0);
    reset = 1'b1;
    tick();

    // Full dump with tx_done 3 cycles after each tx_start.
    clear_logs();
    d0 = 3;
    pulse_start0();
    wait_done0("full", 2000);
    check_dump0("full");
    check_output("full busy in DONE", {31'd0, busy0}, 32'd1);
    tick();
    check_output("full busy after", {31'd0, busy0}, 32'd0);
    check_output("full done count", 32'(done_cnt0), 32'd1);
    check_output("full mem_wr", {31'd0, mem_wr0}, 32'd0);

    // Back-to-back: 5 cycles per word, 50 from RD_REQ(0) to DONE.
    clear_logs();
    d0 = 1;
    pulse_start0();
    wait_done0("b2b", 1000);
    check_dump0("b2b");
    check_output("b2b cycles", 32'(done_cyc0 - first_rd_cyc0), 32'd50);
    tick();
    check_output("b2b busy after", {31'd0, busy0}, 32'd0);

    // start held high plus spurious tx_done in SEND_HI; restart only after DONE.
    clear_logs();
    d0          = 1;
    inject_spur = 1'b1;
    start0      = 1'b1;
    wait_done0("noise", 1000);
    check_dump0("noise");
    tick();
    check_output("noise idle gap", {31'd0, busy0}, 32'd0);
    tick();
    check_output("noise restart busy", {31'd0, busy0}, 32'd1);
    check_output("noise restart rd", {31'd0, mem_rd0}, 32'd1);
    check_output("noise restart addr", {21'd0, mem_addr0}, 32'd0);
    start0    = 1'b0;
    done_cnt0 = 0;
    wait_done0("noise second", 1000);
    check_output("noise second bytes", 32'(byte_q0.size()), 32'd40);
    inject_spur = 1'b0;
    tick();

    // Reset asserted in WAIT_LO of word 4.
    clear_logs();
    d0 = 3;
    pulse_start0();
    for (int n = 0; n < 500 && byte_q0.size() < 10; n++) tick();
    check_output("mid reach word4 lo", 32'(byte_q0.size()), 32'd10);
    tick();
    check_output("mid in WAIT_LO", {31'd0, tx_start0}, 32'd0);
    check_output("mid tx_data", {24'd0, tx_data0}, 32'h04);
    reset = 1'b0;
    #1;
    check_output("mid reset busy", {31'd0, busy0}, 32'd0);
    check_output("mid reset addr", {21'd0, mem_addr0}, 32'd0);
    check_output("mid reset tx_data", {24'd0, tx_data0}, 32'd0);
    check_output("mid reset tx_start", {31'd0, tx_start0}, 32'd0);
    check_output("mid reset mem_rd", {31'd0, mem_rd0}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    clear_logs();
    d0 = 1;
    pulse_start0();
    wait_done0("post reset", 1000);
    check_dump0("post reset");
    tick();

    // Single-word instance.
    byte_q1.delete();
    rd_cnt1   = 0;
    max_addr1 = 0;
    done_cnt1 = 0;
    start1    = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 200 && done_cnt1 == 0; n++) tick();
    check_output("n1 done", 32'(done_cnt1), 32'd1);
    check_output("n1 byte count", 32'(byte_q1.size()), 32'd2);
    check_output("n1 hi byte", {24'd0, (byte_q1.size() > 0) ? byte_q1[0] : 8'hxx}, 32'hBE);
    check_output("n1 lo byte", {24'd0, (byte_q1.size() > 1) ? byte_q1[1] : 8'hxx}, 32'hEF);
    check_output("n1 reads", 32'(rd_cnt1), 32'd1);
    check_output("n1 max addr", 32'(max_addr1), 32'd0);
    tick();
    check_output("n1 busy after", {31'd0, busy1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
